// File: rtl/disp_sched.sv
// Arbitrated two-digit seven-segment sequencer: picks an owner at each frame boundary, then shows
// tens, blank, ones, blank from a value latched at frame start; all outputs come straight from flops.
module disp_sched #(
  parameter int DWELL       = 4,
  parameter int BLANK       = 1,
  parameter int HOLD_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic [7:0] a_val,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic [7:0] b_val,
  output logic       b_gnt,
  output logic [6:0] seg,
  output logic       digit_sel
);

  localparam int MAXD = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXD < 2) ? 1 : $clog2(MAXD);
  localparam int HW   = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST  = CW'(BLANK - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  typedef enum logic [2:0] {IDLE, TENS, BLANK_T, ONES, BLANK_O} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    val_q, val_d;
  logic          last_owner_q, last_owner_d;  // 0 = A, 1 = B
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [6:0]    seg_q, seg_d;
  logic          digit_sel_q, digit_sel_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          frame_end;
  logic          win_b;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    val_d        = val_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    frame_end    = 1'b0;
    win_b        = 1'b0;

    case (state_q)
      IDLE: frame_end = 1'b1;
      TENS: if (cnt_q == DW_LAST) begin
        cnt_d   = '0;
        state_d = (BLANK > 0) ? BLANK_T : ONES;
      end
      BLANK_T: if (cnt_q == BL_LAST) begin
        cnt_d   = '0;
        state_d = ONES;
      end
      ONES: if (cnt_q == DW_LAST) begin
        if (BLANK > 0) begin
          cnt_d   = '0;
          state_d = BLANK_O;
        end else begin
          frame_end = 1'b1;
        end
      end
      BLANK_O: if (cnt_q == BL_LAST) frame_end = 1'b1;
      default: state_d = IDLE;
    endcase

    // Ownership only changes here; a fresh start from IDLE always favours the non-last owner on a tie.
    if (frame_end) begin
      cnt_d = '0;
      if (!a_req && !b_req) begin
        state_d = IDLE;
      end else begin
        if (a_req && b_req)
          win_b = (state_q != IDLE && hold_cnt_q < HOLD_MAX) ? last_owner_q : !last_owner_q;
        else
          win_b = b_req;
        state_d      = TENS;
        val_d        = win_b ? b_val : a_val;
        last_owner_d = win_b;
        if (win_b != last_owner_q)
          hold_cnt_d = HW'(1);
        else if (hold_cnt_q != HOLD_MAX)
          hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end

    seg_d = 7'b0000000;
    if (state_d == TENS) seg_d = decode(val_d[7:4]);
    if (state_d == ONES) seg_d = decode(val_d[3:0]);
    digit_sel_d = (state_d == TENS);
    a_gnt_d     = (state_d != IDLE) && !last_owner_d;
    b_gnt_d     = (state_d != IDLE) &&  last_owner_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      val_q        <= '0;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      seg_q        <= '0;
      digit_sel_q  <= 1'b0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      val_q        <= val_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      seg_q        <= seg_d;
      digit_sel_q  <= digit_sel_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;
  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched (DWELL=4, BLANK=1, HOLD_FRAMES=2, 10-cycle frames).
// Table rows: inputs held during cycle i, expected outputs observed in cycle i+1.
module tb_disp_sched;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [7:0] a_val = 8'h00, b_val = 8'h00;
  logic [6:0] seg;
  logic       digit_sel, a_gnt, b_gnt;
  int         n_cmp = 0;
  int         n_fail = 0;

  localparam logic [6:0] S0 = 7'b0000000;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;

  always #5 clk = ~clk;

  disp_sched #(.DWELL(4), .BLANK(1), .HOLD_FRAMES(2)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_val(a_val), .a_gnt(a_gnt),
    .b_req(b_req), .b_val(b_val), .b_gnt(b_gnt),
    .seg(seg), .digit_sel(digit_sel)
  );

  typedef struct {
    logic       rst;
    logic       a_req;
    logic [7:0] a_val;
    logic       b_req;
    logic [7:0] b_val;
    logic [6:0] seg;
    logic       dsel;
    logic       ag;
    logic       bg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ar, input logic [7:0] av,
                              input logic br, input logic [7:0] bv,
                              input logic [6:0] s, input logic d, input logic ag, input logic bg);
    vec_t v;
    v.rst = r; v.a_req = ar; v.a_val = av; v.b_req = br; v.b_val = bv;
    v.seg = s; v.dsel = d; v.ag = ag; v.bg = bg;
    return v;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'b0111111; 4'd1: dec7 = 7'b0000110; 4'd2: dec7 = 7'b1011011;
      4'd3: dec7 = 7'b1001111; 4'd4: dec7 = 7'b1100110; 4'd5: dec7 = 7'b1101101;
      4'd6: dec7 = 7'b1111101; 4'd7: dec7 = 7'b0000111; 4'd8: dec7 = 7'b1111111;
      4'd9: dec7 = 7'b1101111; default: dec7 = 7'b0000000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [6:0] es, input logic ed,
                     input logic ea, input logic eb);
    n_cmp++;
    if ({seg, digit_sel, a_gnt, b_gnt} !== {es, ed, ea, eb}) begin
      n_fail++;
      $display("FAIL %s: got seg=%b dsel=%b a_gnt=%b b_gnt=%b, want seg=%b dsel=%b a_gnt=%b b_gnt=%b",
               nm, seg, digit_sel, a_gnt, b_gnt, es, ed, ea, eb);
    end
  endtask

  // Expected outputs at position pos (0..9) of a frame showing val.
  task automatic chk_frame(input string nm, input int pos, input logic [7:0] val,
                           input logic ea, input logic eb);
    if (pos < 4)       chk(nm, dec7(val[7:4]), 1'b1, ea, eb);
    else if (pos == 4) chk(nm, S0, 1'b0, ea, eb);
    else if (pos < 9)  chk(nm, dec7(val[3:0]), 1'b0, ea, eb);
    else               chk(nm, S0, 1'b0, ea, eb);
  endtask

  initial begin
    // Single requester A 0x23, then 0x2A frame (non-BCD ones), drop, then B alone, then reset.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, S2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, S0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, S3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h23, 0, 8'h00, S0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 8'h2A, 0, 8'h00, S2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h2A, 0, 8'h00, S0, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 8'h2A, 0, 8'h00, S0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h2A, 0, 8'h00, S0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h2A, 0, 8'h00, S0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h45, S4, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h45, S4, 1, 0, 1));
    tbl.push_back(mk(1, 1, 8'h23, 1, 8'h45, S0, 0, 0, 0));

    // Reset state and idle with no requests.
    reset = 1'b1;
    tick; tick;
    chk("reset_state", S0, 0, 0, 0);
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      chk($sformatf("idle_c%0d", c), S0, 0, 0, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; a_req = tbl[i].a_req; a_val = tbl[i].a_val;
      b_req = tbl[i].b_req; b_val = tbl[i].b_val;
      tick;
      chk($sformatf("tbl_row%0d", i), tbl[i].seg, tbl[i].dsel, tbl[i].ag, tbl[i].bg);
    end

    // Mid-frame value change and request drop do not disturb the current frame.
    reset = 1'b0; b_req = 1'b0; a_req = 1'b1; a_val = 8'h23;
    for (int c = 1; c <= 11; c++) begin
      tick;
      if (c == 3) begin a_val = 8'h99; a_req = 1'b0; end
      if (c <= 10) chk_frame($sformatf("midchg_c%0d", c), c - 1, 8'h23, 1, 0);
      else         chk($sformatf("midchg_c%0d", c), S0, 0, 0, 0);
    end

    // Contention from IDLE: A 2 frames, B 2 frames, A 2 frames.
    reset = 1'b1; tick; reset = 1'b0;
    a_req = 1'b1; a_val = 8'h23; b_req = 1'b1; b_val = 8'h45;
    for (int c = 1; c <= 60; c++) begin
      int  f;
      logic own_a;
      tick;
      f = (c - 1) / 10;
      own_a = ((f % 4) < 2);
      chk_frame($sformatf("contend_c%0d", c), (c - 1) % 10, own_a ? 8'h23 : 8'h45, own_a, !own_a);
    end

    // Reset mid-frame of A's frame; A must still win the first tie afterwards.
    reset = 1'b1; tick; reset = 1'b0;
    for (int c = 1; c <= 7; c++) tick;
    chk("rstmid_pre_c7", S3, 0, 1, 0);
    reset = 1'b1;
    tick;
    chk("rstmid_c8", S0, 0, 0, 0);
    reset = 1'b0;
    for (int c = 9; c <= 18; c++) begin
      tick;
      chk_frame($sformatf("rstmid_c%0d", c), c - 9, 8'h23, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Grants must never overlap.
  always @(negedge clk) begin
    if (a_gnt && b_gnt) begin
      n_cmp++;
      n_fail++;
      $display("FAIL grant_overlap: got a_gnt=1 b_gnt=1, want at most one high");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/disp_sched.md
# disp_sched

Display scheduler that shares the two-digit seven-segment output between two requesters and sequences it. The block arbitrates between requesters at frame boundaries and latches the winner's two-digit BCD value. It then time-multiplexes the tens and ones digits, with optional blanking gaps between them to suppress ghosting. It sits between the application logic and `uo_out`, replacing free-running divide-by-2 digit multiplexing with a dwell-controlled, arbitrated sequencer.

## Interface
- `DWELL`, 4: cycles each digit is lit; must be ≥1.
- `BLANK`, 1: blank cycles after each digit; ≥0; when 0 the blank states are skipped.
- `HOLD_FRAMES`, 2: minimum consecutive frames an owner keeps the display when the other requester is also waiting; ≥1.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `a_req` in 1: requester A wants the display (level).
- `a_val` in 8: requester A BCD value; [7:4] tens, [3:0] ones.
- `a_gnt` out 1: A owns the current frame.
- `b_req` in 1: requester B wants the display (level).
- `b_val` in 8: requester B BCD value, same layout as `a_val`.
- `b_gnt` out 1: B owns the current frame.
- `seg` out 7: segment pattern, bit order gfedcba, active-high.
- `digit_sel` out 1: 1 = tens digit lit, 0 otherwise.

## Operation
- States: IDLE, TENS, BLANK_T, ONES, BLANK_O.
- Frame sequence: TENS (DWELL cycles) → BLANK_T (BLANK cycles) → ONES (DWELL cycles) → BLANK_O (BLANK cycles). Frame length is 2·(DWELL+BLANK) cycles.
- Arbitration happens only at a frame boundary: in IDLE, or in the last cycle of BLANK_O (the last cycle of ONES when BLANK=0).
  - No request: go to IDLE.
  - One request: that requester wins.
  - Both requesting, current owner has held < HOLD_FRAMES consecutive frames: owner keeps the display.
  - Both requesting, owner has held ≥ HOLD_FRAMES frames, or coming from IDLE: the requester that is not `last_owner` wins.
- On a win: latch the winner's value into an internal register, set `owner`/`last_owner`, and update `hold_cnt` (reset to 1 on owner change, else +1, saturating at HOLD_FRAMES).
- The value is sampled only at the frame start. Changes to `*_val` or deassertion of `*_req` mid-frame do not affect the current frame.
- `a_gnt`/`b_gnt` are high for every cycle of a frame owned by that requester, including blank cycles, and low in IDLE. Never both high.
- `seg`:
  - In TENS/ONES, decode of the latched nibble: 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - Nibbles A–F decode to 0000000.
  - In IDLE and BLANK states, 0000000.
- `digit_sel` = 1 only in TENS.
- Reset (any state, any cycle):
  - state = IDLE; `seg`, `digit_sel`, `a_gnt`, `b_gnt` = 0.
  - `last_owner` = B, so A wins the first tie.
  - `hold_cnt` = 0; latched value = 0.
  - Reset takes priority over all requests in the same cycle.

## Timing
- All outputs are driven from registers or from the state register. No combinational path from `*_req` or `*_val` to any output.
- Request in IDLE sampled at edge N: TENS is active from cycle N+1, with the grant high and tens segments shown in that same cycle.
- Dwell counter counts 0..DWELL−1 (or BLANK−1) and wraps to 0 on every state change. Its width is sized for max(DWELL, BLANK).
- Back-to-back frames: the cycle after the last BLANK_O cycle is the first TENS cycle of the next frame. There are no idle gaps while any request is pending.
- Owner switch takes effect on the first TENS cycle of the new frame. The old grant drops and the new grant rises in the same cycle.
- Request dropped mid-frame: the frame completes and the grant stays high to the frame end. The next cycle is IDLE, or the other requester's frame.

## Test plan
All scenarios use DWELL=4, BLANK=1, HOLD_FRAMES=2 (frame = 10 cycles).

- **Idle after reset.** Reset, then no requests for 20 cycles → `seg`=0000000, `digit_sel`=0, both grants 0 throughout.
- **Single requester.** `a_req`=1, `a_val`=8'h23 sampled at edge 0 →
  - cycles 1–4: `seg`=1011011, `digit_sel`=1, `a_gnt`=1;
  - cycle 5: `seg`=0;
  - cycles 6–9: `seg`=1001111, `digit_sel`=0;
  - cycle 10: blank;
  - cycle 11: tens again.
- **Contention from IDLE.** Both requesting from IDLE, `a_val`=8'h23, `b_val`=8'h45 → A owns frames 1–2 (cycles 1–20), B owns frames 3–4 showing 4 then 5, A owns frames 5–6. Grants are never simultaneously high.
- **Non-BCD digit.** `a_val`=8'h2A → tens shows 1011011, ones cycles show 0000000, `digit_sel` timing unchanged.
- **Mid-frame changes.** In the frame starting at cycle 1, change `a_val` to 8'h99 and drop `a_req` at cycle 3 → the frame still shows 2/3 and `a_gnt` stays high through cycle 10. Cycle 11 is IDLE with all outputs 0.
- **Reset mid-frame.** Reset asserted at cycle 7 of an active frame → from cycle 8 all outputs are 0 and the state is IDLE. Release reset with both requesting → A wins the first frame.
